// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
//   periodOut = cycles between consecutive rising edges of the conditioned input
//   activeOut = cycles the conditioned input was high within that period
//   captureValid pulses for one cycle whenever both outputs update.
//   timeout is a level that rises when no edge arrives within 2^W-1 cycles.
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a glitch filter that
// only lets the conditioned level change after FILT_LEN identical samples.
// Without the macro the conditioned level is simply the synchronized input.
module pwm_capture #(
  parameter int W        = 16,
  parameter int FILT_LEN = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         pwmIn,
  output logic [W-1:0] periodOut,
  output logic [W-1:0] activeOut,
  output logic         captureValid,
  output logic         timeout
);

  // Saturation point of the period counter; reaching it without an edge is a timeout.
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  logic   s1;
  logic   s2;
  logic   lvl;
  logic   lvl_d;
  logic   rise;
  state_t state;
  logic [W-1:0] period_cnt;
  logic [W-1:0] active_cnt;

  // Two-flop synchronizer for the asynchronous input; keeps sampling even when disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwmIn;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Counter width must hold values up to FILT_LEN-1.
  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

  logic [FW-1:0] filt_cnt;
  logic          filt_lvl;

  // Glitch filter: accept a new level only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (s2 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_lvl <= s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = s2;
`endif

  // One-cycle delayed copy of the conditioned level for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;

  // Measurement FSM: counts period and high time between rises, captures on each rise,
  // and parks in TIMEOUT if the period counter saturates before the next rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      period_cnt   <= '0;
      active_cnt   <= '0;
      periodOut    <= '0;
      activeOut    <= '0;
      captureValid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      captureValid <= 1'b0;
      if (!enable) begin
        // Abandon any measurement in progress; the last results stay visible.
        state      <= IDLE;
        period_cnt <= '0;
        active_cnt <= '0;
        timeout    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // First rise only opens a measurement window; nothing to report yet.
            if (rise) begin
              state      <= MEASURE;
              period_cnt <= CNT_ONE;
              active_cnt <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (rise) begin
              // A rise wins over the timeout threshold in the same cycle.
              periodOut    <= period_cnt;
              activeOut    <= active_cnt;
              captureValid <= 1'b1;
              period_cnt   <= CNT_ONE;
              active_cnt   <= CNT_ONE;
            end else if (period_cnt == CNT_MAX) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
            end else begin
              period_cnt <= period_cnt + CNT_ONE;
              active_cnt <= active_cnt + {{(W-1){1'b0}}, lvl};
            end
          end
          TIMEOUT: begin
            // Counters stay frozen; a fresh rise restarts measurement without a capture.
            if (rise) begin
              state      <= MEASURE;
              period_cnt <= CNT_ONE;
              active_cnt <= CNT_ONE;
              timeout    <= 1'b0;
            end
          end
          default: begin
            state      <= IDLE;
            period_cnt <= '0;
            active_cnt <= '0;
            timeout    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (default build, no input filter), W=8 so timeouts are short.
// Reference model works on timestamps: it keeps the per-cycle history of the input,
// derives the conditioned level as the input two clocks earlier, finds rising edges,
// and reports period = time between rises and active = number of high cycles in between.
module tb_pwm_capture;

  localparam int W     = 8;
  localparam int MAX   = (1 << W) - 1;
  localparam int DEPTH = 16384;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_in;
  logic [W-1:0] period_out;
  logic [W-1:0] active_out;
  logic         capture_valid;
  logic         timeout;

  pwm_capture #(.W(W), .FILT_LEN(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .pwmIn        (pwm_in),
    .periodOut    (period_out),
    .activeOut    (active_out),
    .captureValid (capture_valid),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;
  int captures    = 0;
  bit p_hist [DEPTH];

  // Reference model state: measuring window open, time of last rise, expected outputs.
  bit meas   = 1'b0;
  bit timed  = 1'b0;
  bit exp_cv = 1'b0;
  int t0     = 0;
  int exp_per = 0;
  int exp_act = 0;

  // Conditioned level seen by the measurement logic at edge j.
  function automatic bit lvl_at(input int j);
    if (j < 2) return 1'b0;
    return p_hist[j-2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, expv, k);
    end
  endtask

  // Apply one clock of stimulus, advance the model, compare all outputs.
  task automatic step(input bit p, input bit en, input bit rst);
    bit rise;
    int sum;
    pwm_in = p;
    enable = en;
    reset  = rst;
    @(posedge clock);
    k++;
    if (k >= DEPTH) begin
      $display("FAIL history_overflow observed=%0d required<%0d", k, DEPTH);
      $fatal(1, "history buffer exhausted");
    end
    p_hist[k] = p;
    #1;
    if (rst) begin
      // Synchronizer cleared: the two samples in flight are effectively zero.
      p_hist[k]   = 1'b0;
      p_hist[k-1] = 1'b0;
      meas = 0; timed = 0; exp_cv = 0; exp_per = 0; exp_act = 0;
    end else if (!en) begin
      meas = 0; timed = 0; exp_cv = 0;
    end else begin
      rise = lvl_at(k) && !lvl_at(k-1);
      exp_cv = 1'b0;
      if (rise) begin
        if (meas) begin
          sum = 0;
          for (int j = t0; j < k; j++) sum += int'(lvl_at(j));
          exp_cv  = 1'b1;
          exp_per = k - t0;
          exp_act = sum;
        end
        meas  = 1'b1;
        timed = 1'b0;
        t0    = k;
      end else if (meas && (k - t0 >= MAX)) begin
        meas  = 1'b0;
        timed = 1'b1;
      end
    end
    check("captureValid", {31'd0, capture_valid}, {31'd0, exp_cv});
    check("timeout",      {31'd0, timeout},       {31'd0, timed});
    check("periodOut",    {24'd0, period_out},    exp_per);
    check("activeOut",    {24'd0, active_out},    exp_act);
    if (exp_cv) begin
      captures++;
      $display("capture %0d @cycle %0d: period=%0d active=%0d", captures, k, exp_per, exp_act);
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < per; c++) step(c < hi, 1'b1, 1'b0);
  endtask

  task automatic hold(input bit v, input int n);
    for (int c = 0; c < n; c++) step(v, 1'b1, 1'b0);
  endtask

  initial begin
    int per;
    int hi;
    // Reset and quiet input.
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 5);
    // Steady waveform, then a period/duty change mid-stream.
    wave(10, 3, 6);
    wave(25, 20, 4);
    // Minimum pulse widths.
    wave(2, 1, 5);
    wave(3, 2, 4);
    // Random period/duty segments.
    for (int s = 0; s < 10; s++) begin
      per = $urandom_range(60, 4);
      hi  = $urandom_range(per - 1, 1);
      wave(per, hi, $urandom_range(4, 2));
    end
    // Timeout with constant low, then recovery.
    wave(10, 3, 2);
    hold(1'b0, 300);
    wave(12, 5, 3);
    // Timeout with constant high, then recovery.
    hold(1'b1, 300);
    hold(1'b0, 5);
    wave(12, 5, 3);
    // Longest reportable period, then one cycle too long.
    wave(255, 1, 3);
    wave(256, 1, 2);
    wave(9, 4, 3);
    // Reset 5 cycles into a period-40 measurement.
    wave(40, 15, 2);
    hold(1'b1, 5);
    step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 1);
    wave(40, 15, 3);
    // Enable dropped mid-period, then restored.
    wave(30, 10, 3);
    for (int c = 0; c < 15; c++) step(c < 10, 1'b1, 1'b0);
    for (int c = 15; c < 30; c++) step(c < 10, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) step(c < 10, 1'b0, 1'b0);
    wave(30, 10, 3);
    // Two-cycle glitch inside the low phase of a period-20 high-8 wave.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 20; c++) step((c < 8) || (c == 12) || (c == 13), 1'b1, 1'b0);
    wave(20, 8, 2);
    // Random bit stream with occasional enable drops.
    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(1, 0)), ($urandom_range(15, 0) != 0), 1'b0);
    wave(17, 6, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
